uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Receive-side counterpart of the UART transmit path: samples the serial line and reassembles 8N1/8E1/8N2/8E2 frames.
- Presents each received byte on a valid/ready handshake, with parity and framing error flags.
- Sits between the RX pin and the RX FIFO feeding the APB register block.
- Timing comes from an external 16x oversampling strobe supplied by the baud generator.

Parameters:
- OVERSAMPLE, 16, baud_tick_i strobes per bit period (even, >= 8)
- SYNC_STAGES, 2, flip-flop stages in the rx_i synchronizer (>= 2)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; one clock, reset is synchronous and active-high
- baud_tick_i  input  1  oversample strobe, one clk_i wide, OVERSAMPLE per bit
- rx_i  input  1  asynchronous serial line, idle high
- parity_en_i  input  1  frame carries an even-parity bit after DATA_7
- extra_stop_i  input  1  frame carries a second stop bit
- data_o  output  8  received byte, LSB first on the line
- data_valid_o  output  1  data_o holds an unconsumed byte
- data_ready_i  input  1  consumer accepts data_o
- parity_err_o  output  1  parity error for the byte on data_o
- frame_err_o  output  1  stop bit(s) sampled low for the byte on data_o
- overrun_o  output  1  one-cycle pulse: a frame completed while data_valid_o=1 and data_ready_i=0
- state_o  output  4  current state (uart_rx_state_e), debug/status

Behaviour:
- Reset values: state IDLE; data_o=0; data_valid_o=0; parity_err_o=0; frame_err_o=0; overrun_o=0; tick counter=0; synchronizer stages=1.
- Reset mid-frame aborts the frame without producing output. rst_i has priority over all other events.
- rx_i passes through SYNC_STAGES flops; all logic uses the synchronized value rxs.
- States: IDLE, START_BIT, DATA_0..DATA_7, PARITY_BIT, STOP_BIT, EXTRA_STOP.
- Tick counter is log2(OVERSAMPLE) bits wide, advances only on baud_tick_i, and clears on every state change.
- IDLE: rxs==0 -> START_BIT (counter=0). No baud_tick_i needed to leave IDLE.
- START_BIT: on the baud_tick_i making counter reach OVERSAMPLE/2-1 (mid-bit), sample rxs.
  - rxs==1: false start -> IDLE, nothing reported.
  - rxs==0: -> DATA_0.
- DATA_n, PARITY_BIT, STOP_BIT, EXTRA_STOP: sample rxs on the baud_tick_i making counter reach OVERSAMPLE-1, i.e. one full bit after the previous sample point.
- DATA_n: shift rxs into bit n of the shift register. DATA_n -> DATA_n+1.
- DATA_7 -> PARITY_BIT if parity_en_i, else STOP_BIT.
- PARITY_BIT: perr = rxs XOR (XOR of the 8 data bits); error when the total count of ones is odd. -> STOP_BIT.
- STOP_BIT: ferr = !rxs. -> EXTRA_STOP if extra_stop_i, else complete.
- EXTRA_STOP: ferr |= !rxs. -> complete.
- parity_en_i and extra_stop_i are sampled when each decision is taken. Software changes them only while idle.
- Complete (same cycle as the last stop-bit sample): state -> IDLE. A low rxs on the next cycle starts a new frame immediately, so back-to-back frames are supported.
- At complete, if data_valid_o==0 or data_ready_i==1:
  - data_o, parity_err_o, frame_err_o load the new values on the next edge.
  - data_valid_o=1.
  - Latency: data_valid_o rises 1 clk_i after the final stop-bit sample.
- At complete, if data_valid_o==1 and data_ready_i==0:
  - The new byte is dropped; held outputs are unchanged.
  - overrun_o pulses high for 1 cycle.
- Handshake: transfer when data_valid_o && data_ready_i. data_valid_o clears on the following edge unless a completion loads a new byte in that same cycle, in which case it stays 1 with the new data.
- data_o and the error flags stay stable while data_valid_o=1 and no transfer occurs.
- A framing error with rxs held low (break) still completes the frame. The FSM then waits in IDLE, re-enters START_BIT, and keeps getting false starts only if the line returns high mid-bit. Otherwise it receives 0x00 frames with ferr=1.
- Invalid state encodings -> IDLE.

Test Plan:
- OVERSAMPLE=16, 8N1, send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) with data_ready_i=0 -> data_o=0xA5, data_valid_o=1, parity_err_o=0, frame_err_o=0 one clk after the stop sample. Assert data_ready_i -> data_valid_o=0 next cycle.
- 8E1: send 0x03 with parity bit 0 -> parity_err_o=0. Send 0x03 with parity bit 1 -> parity_err_o=1, data_o=0x03.
- 8N2: send 0x5A with the second stop bit driven 0 -> frame_err_o=1, data_o=0x5A. Then drive rx_i high -> returns to IDLE, no spurious frame.
- Glitch: rx_i low for 4 baud ticks then high -> false start, state_o returns to IDLE, data_valid_o stays 0.
- Overrun: two back-to-back 8N1 frames 0x11 then 0x22, data_ready_i=0 -> data_o=0x11 held, overrun_o pulses once at the second completion. Same stimulus with data_ready_i=1 -> both bytes delivered, no overrun.
- Reset: assert rst_i during DATA_3 of frame 0x7E, release, then send 0xC3 -> only 0xC3 is delivered, with no error flags.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receiver for 8N1/8E1/8N2/8E2 frames with a valid/ready byte output and error flags.
module uart_rx_fsm #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       baud_tick_i,
    input  logic       rx_i,
    input  logic       parity_en_i,
    input  logic       extra_stop_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    input  logic       data_ready_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        IDLE, START_BIT,
        DATA_0, DATA_1, DATA_2, DATA_3, DATA_4, DATA_5, DATA_6, DATA_7,
        PARITY_BIT, STOP_BIT, EXTRA_STOP
    } uart_rx_state_e;

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    uart_rx_state_e         state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [7:0]             shift;
    logic [2:0]             bit_idx;
    logic                   rxs, sample, complete, accept, perr, ferr, ferr_new;

    assign rxs     = sync[SYNC_STAGES-1];
    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            sync  <= '1;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CW'(baud_tick_i);
            sync  <= {sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = rxs ? IDLE : START_BIT;
            START_BIT:  if (sample) state_next = rxs ? IDLE : DATA_0;
            DATA_0, DATA_1, DATA_2, DATA_3, DATA_4, DATA_5, DATA_6:
                        if (sample) state_next = uart_rx_state_e'(state + 4'd1);
            DATA_7:     if (sample) state_next = parity_en_i ? PARITY_BIT : STOP_BIT;
            PARITY_BIT: if (sample) state_next = STOP_BIT;
            STOP_BIT:   if (sample) state_next = extra_stop_i ? EXTRA_STOP : IDLE;
            EXTRA_STOP: if (sample) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // The start bit is sampled half a bit in; every later bit one full bit after that.
    always_comb begin
        sample   = baud_tick_i && cnt == (state == START_BIT ? MID : LAST);
        complete = sample && ((state == STOP_BIT && !extra_stop_i) || state == EXTRA_STOP);
        accept   = complete && (!data_valid_o || data_ready_i);
        ferr_new = !rxs || (state == EXTRA_STOP && ferr);
        bit_idx  = 3'(state - DATA_0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                perr <= 1'b0;
                ferr <= 1'b0;
            end
            if (sample && state >= DATA_0 && state <= DATA_7) shift[bit_idx] <= rxs;
            if (sample && state == PARITY_BIT) perr <= rxs ^ (^shift);
            if (sample && state == STOP_BIT) ferr <= !rxs;
            if (accept) begin
                data_o       <= shift;
                parity_err_o <= perr;
                frame_err_o  <= ferr_new;
            end
            data_valid_o <= accept || (data_valid_o && !data_ready_i);
            overrun_o    <= complete && data_valid_o && !data_ready_i;
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames with hand-computed expectations for uart_rx_fsm.
module tb_uart_rx_fsm;
    localparam int BIT = 64;
    localparam logic [3:0] ST_IDLE = 4'd0, ST_START = 4'd1, ST_D3 = 4'd5;

    logic       clk_i = 0, rst_i = 1, baud_tick_i = 0, rx_i = 1;
    logic       parity_en_i = 0, extra_stop_i = 0, data_ready_i = 0;
    logic [7:0] data_o;
    logic       data_valid_o, parity_err_o, frame_err_o, overrun_o;
    logic [3:0] state_o;
    int         checks = 0, errors = 0, ovr_cnt = 0, phase = 0, n;
    logic       pv;
    logic [7:0] v;
    logic [7:0] got_q[$];

    uart_rx_fsm dut (
        .clk_i(clk_i), .rst_i(rst_i), .baud_tick_i(baud_tick_i), .rx_i(rx_i),
        .parity_en_i(parity_en_i), .extra_stop_i(extra_stop_i), .data_o(data_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(negedge clk_i);
        baud_tick_i = (phase == 3);
        phase = (phase + 1) % 4;
    end

    always @(posedge clk_i) begin
        #1;
        if (overrun_o) ovr_cnt++;
        if (data_valid_o && data_ready_i) got_q.push_back(data_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b, input int clocks);
        rx_i = b;
        repeat (clocks) @(negedge clk_i);
    endtask

    task automatic send_data(input logic [7:0] d);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        send_data(d);
        if (parity_en_i) drive(p, BIT);
        drive(1'b1, BIT);
        if (extra_stop_i) drive(1'b1, BIT);
    endtask

    task automatic consume();
        data_ready_i = 1;
        @(negedge clk_i);
        data_ready_i = 0;
        check("consume_clears_valid", data_valid_o, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_state", state_o, ST_IDLE);
        check("rst_data", data_o, 0);
        check("rst_valid", data_valid_o, 0);
        check("rst_perr", parity_err_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        rst_i = 0;
        drive(1'b1, BIT);

        // 8N1 0xA5 with exact valid latency around the stop-bit sample
        send_data(8'hA5);
        rx_i = 1;
        n = 0;
        pv = 0;
        while (state_o != ST_IDLE && n < BIT) begin
            pv = data_valid_o;
            @(negedge clk_i);
            n++;
        end
        check("a5_stop_seen", n < BIT, 1);
        check("a5_valid_before", pv, 0);
        check("a5_valid_with_idle", data_valid_o, 1);
        repeat (BIT - n) @(negedge clk_i);
        check("a5_data", data_o, 8'hA5);
        check("a5_perr", parity_err_o, 0);
        check("a5_ferr", frame_err_o, 0);
        consume();

        // 8E1 good and bad parity
        parity_en_i = 1;
        send_frame(8'h03, 1'b0);
        check("e1_good_data", data_o, 8'h03);
        check("e1_good_perr", parity_err_o, 0);
        consume();
        send_frame(8'h03, 1'b1);
        check("e1_bad_data", data_o, 8'h03);
        check("e1_bad_perr", parity_err_o, 1);
        check("e1_bad_ferr", frame_err_o, 0);
        consume();
        parity_en_i = 0;

        // 8N2 with second stop low, then line returns high
        extra_stop_i = 1;
        ovr_cnt = 0;
        send_data(8'h5A);
        drive(1'b1, BIT);
        drive(1'b0, 48);
        drive(1'b1, 16);
        check("n2_data", data_o, 8'h5A);
        check("n2_ferr", frame_err_o, 1);
        check("n2_perr", parity_err_o, 0);
        drive(1'b1, 3 * BIT);
        check("n2_idle", state_o, ST_IDLE);
        check("n2_held", data_o, 8'h5A);
        check("n2_no_spurious", ovr_cnt, 0);
        consume();
        extra_stop_i = 0;

        // glitch: 4 ticks low then high
        drive(1'b0, 10);
        check("glitch_start", state_o, ST_START);
        drive(1'b0, 6);
        drive(1'b1, BIT);
        check("glitch_idle", state_o, ST_IDLE);
        check("glitch_no_valid", data_valid_o, 0);

        // overrun with consumer stalled
        ovr_cnt = 0;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        check("ovr_held_data", data_o, 8'h11);
        check("ovr_valid", data_valid_o, 1);
        check("ovr_pulses", ovr_cnt, 1);
        consume();

        // same stimulus with consumer always ready
        got_q.delete();
        ovr_cnt = 0;
        data_ready_i = 1;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        data_ready_i = 0;
        check("rdy_count", got_q.size(), 2);
        check("rdy_first", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h11);
        check("rdy_second", got_q.size() > 1 ? got_q[1] : 8'h00, 8'h22);
        check("rdy_no_ovr", ovr_cnt, 0);

        // reset during DATA_3 of 0x7E, then 0xC3
        v = 8'h7E;
        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(v[i], BIT);
        drive(v[3], 16);
        check("rst_mid_state", state_o, ST_D3);
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        check("rst_mid_idle", state_o, ST_IDLE);
        drive(1'b1, 10 * BIT);
        check("rst_mid_no_valid", data_valid_o, 0);
        ovr_cnt = 0;
        send_frame(8'hC3, 1'b0);
        check("c3_data", data_o, 8'hC3);
        check("c3_valid", data_valid_o, 1);
        check("c3_perr", parity_err_o, 0);
        check("c3_ferr", frame_err_o, 0);
        check("c3_no_ovr", ovr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
